divide_unit: RTL
================

DIVIDE_UNIT -- requirements
Module: divide_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; the block SHALL support any even WIDTH >= 4.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request; sampled on the rising edge of clk.
REQ-005 is_signed  input  1  1 = two's-complement divide (div), 0 = unsigned divide (divu); sampled with start.
REQ-006 dividend  input  WIDTH  numerator; sampled with start.
REQ-007 divisor  input  WIDTH  denominator; sampled with start.
REQ-008 busy  output  1  high while an operation is iterating.
REQ-009 done  output  1  single-cycle pulse marking valid results.
REQ-010 quotient  output  WIDTH  result (LO).
REQ-011 remainder  output  WIDTH  result (HI).
REQ-012 div_zero  output  1  high when the last completed operation had divisor == 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 start SHALL be accepted only when busy == 0 (IDLE or DONE); start while in RUN SHALL be ignored with no effect on the operation in flight.
REQ-015 On acceptance, operands, is_signed and the operand sign bits SHALL be latched, the absolute values SHALL be taken when is_signed == 1, and the next state SHALL be RUN (divisor != 0) or DONE (divisor == 0).
REQ-016 RUN SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, using a WIDTH+1-bit partial remainder, then enter DONE.
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; DONE SHALL last one cycle and return to IDLE unless start is accepted in that cycle.
REQ-018 Latency: start accepted at edge N -> busy high during cycles N+1..N+WIDTH, done high in the cycle after edge N+WIDTH+1 (N+1 for divide-by-zero).
REQ-019 Signed fix-up: the quotient SHALL be negated iff the operand signs differ, and the remainder SHALL carry the dividend's sign, giving truncation toward zero.
REQ-020 The signed case of the most-negative value divided by -1 SHALL yield quotient = 1 followed by WIDTH-1 zeros, remainder = 0, with no flag.
REQ-021 Divide-by-zero SHALL skip RUN and yield quotient = all ones, remainder = dividend (as latched, unmodified), div_zero = 1.
REQ-022 quotient, remainder and div_zero SHALL update only on entry to DONE and SHALL hold until the next DONE or reset.
REQ-023 The intermediate values in RUN SHALL NOT be visible on quotient or remainder.
REQ-024 Back-to-back: start accepted in DONE SHALL go directly to RUN (or DONE for a zero divisor), with no IDLE cycle.

Reset
REQ-025 rst high SHALL immediately force IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, and clear all internal registers, regardless of clock.
REQ-026 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Verification
REQ-027 Unsigned: dividend = 100, divisor = 7, is_signed = 0, start at edge N -> busy for 32 cycles, done at N+33, quotient = 14, remainder = 2, div_zero = 0.
REQ-028 Signed: dividend = 0xFFFFFFF9 (-7), divisor = 2, is_signed = 1 -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1).
REQ-029 Divide-by-zero: dividend = 5, divisor = 0 -> done at N+1, busy never high, quotient = 0xFFFFFFFF, remainder = 5, div_zero = 1.
REQ-030 Corner case: dividend = 0x80000000, divisor = 0xFFFFFFFF, is_signed = 1 -> quotient = 0x80000000, remainder = 0, div_zero = 0.
REQ-031 Second start mid-RUN with different operands -> ignored; first result is delivered unchanged and exactly one done pulse occurs.
REQ-032 rst pulsed at RUN cycle 10 -> all outputs 0 immediately, no done pulse; next start with 100/7 -> quotient = 14, remainder = 2 at the nominal latency.

Source files
------------

// File: rtl/divide_unit_if.sv
// divide_unit_if: request/result bundle for divide_unit.
//   start, is_signed, dividend, divisor : request side, driven by the master
//   busy, done, quotient, remainder,
//   div_zero                            : status/result side, driven by the divider
// Modports: master (requester), slave (divider).
interface divide_unit_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/divide_unit.sv
// divide_unit: iterative restoring divider, signed (div) or unsigned (divu).
// One shift-subtract step per cycle for WIDTH cycles; a zero divisor skips the
// iteration and reports quotient = all ones, remainder = dividend, div_zero = 1.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : divide_unit_if.slave (start/is_signed/dividend/divisor in,
//          busy/done/quotient/remainder/div_zero out)
module divide_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   divide_unit_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder (restored, always < divisor)
   logic [WIDTH-1:0] quo_q, quo_d;        // |dividend| shifting out, quotient bits shifting in
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic             quo_neg_q, quo_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH:0]   step_shift;
   logic [WIDTH:0]   step_diff;
   logic             step_ge;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             dvd_neg;
   logic             dvs_neg;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      divisor_d   = divisor_q;
      quo_neg_d   = quo_neg_q;
      rem_neg_d   = rem_neg_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;

      // One restoring step; the borrow out of the WIDTH+1-bit difference
      // decides whether the subtraction is kept.
      step_shift = {rem_q, quo_q[WIDTH-1]};
      step_diff  = step_shift - {1'b0, divisor_q};
      step_ge    = ~step_diff[WIDTH];
      step_rem   = step_ge ? step_diff[WIDTH-1:0] : step_shift[WIDTH-1:0];
      step_quo   = {quo_q[WIDTH-2:0], step_ge};

      dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
      dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               divisor_d = dvs_neg ? -bus.divisor : bus.divisor;
               quo_d     = dvd_neg ? -bus.dividend : bus.dividend;
               rem_d     = '0;
               cnt_d     = '0;
               quo_neg_d = dvd_neg ^ dvs_neg;
               rem_neg_d = dvd_neg;
               if (bus.divisor == '0) begin
                  state_d     = StDone;
                  quotient_d  = '1;
                  remainder_d = bus.dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
               // Negating the magnitude also covers most-negative / -1.
               quotient_d  = quo_neg_q ? -step_quo : step_quo;
               remainder_d = rem_neg_q ? -step_rem : step_rem;
               div_zero_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         quo_q       <= '0;
         divisor_q   <= '0;
         quo_neg_q   <= 1'b0;
         rem_neg_q   <= 1'b0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         divisor_q   <= divisor_d;
         quo_neg_q   <= quo_neg_d;
         rem_neg_q   <= rem_neg_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign bus.busy      = (state_q == StRun);
   assign bus.done      = (state_q == StDone);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.div_zero  = div_zero_q;
endmodule
